// File: rtl/lag_arb_pkg.sv
// Shared types and helpers for the LAG trunk physical-link (PL) arbiter.
//   pl_state_t : per-PL allocation state (FREE, BUSY, DRAIN)
//   credit_w() : bit width of a credit counter that holds 0..buf_len
package lag_arb_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } pl_state_t;

    function automatic int unsigned credit_w(input int unsigned buf_len);
        return $clog2(buf_len + 1);
    endfunction

endpackage

// File: rtl/lag_rr_arbiter.sv
// Combinational round-robin selector.
//   req_i   : NR request lines
//   ptr_i   : index of the highest-priority requester (must be < NR)
//   grant_o : one-hot winner, all-zero when no request is pending
module lag_rr_arbiter #(
    parameter int unsigned NR = 20,
    parameter int unsigned PW = (NR > 1) ? $clog2(NR) : 1
) (
    input  logic [NR-1:0] req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [NR-1:0] grant_o
);

    logic              found;
    logic [PW-1:0]     idx;
    int unsigned       pos;

    // Scan NR positions starting at ptr_i, wrapping around; first hit wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            pos = (32'(ptr_i) + i) % NR;
            idx = PW'(pos);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lag_trunk_pl_arbiter.sv
// Allocates the output PLs of one trunk to NR requesting input PLs and
// tracks downstream credits per PL.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-requester head flit waiting for a PL
//   grant      : one-hot round-robin winner (combinational)
//   grant_pl   : one-hot lowest-index FREE PL given to the winner
//   flit_valid : flit leaves on PL j; flit_tail marks it as a tail
//   credit_in  : downstream returned one credit on PL j
//   pl_free    : PL j is FREE; pl_status: credits nonzero;
//   pl_empty   : credits == BUF_LEN;  err: sticky protocol violation
module lag_trunk_pl_arbiter
    import lag_arb_pkg::*;
#(
    parameter int unsigned NR      = 20,
    parameter int unsigned NPL     = 4,
    parameter int unsigned BUF_LEN = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NR-1:0]  req,
    output logic [NR-1:0]  grant,
    output logic [NPL-1:0] grant_pl,
    input  logic [NPL-1:0] flit_valid,
    input  logic [NPL-1:0] flit_tail,
    input  logic [NPL-1:0] credit_in,
    output logic [NPL-1:0] pl_free,
    output logic [NPL-1:0] pl_status,
    output logic [NPL-1:0] pl_empty,
    output logic           err
);

    localparam int unsigned   CW   = credit_w(BUF_LEN);
    localparam int unsigned   PW   = (NR > 1) ? $clog2(NR) : 1;
    localparam logic [CW-1:0] FULL = CW'(BUF_LEN);

    pl_state_t                state_q [NPL];
    pl_state_t                state_d [NPL];
    logic [NPL-1:0][CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic                     err_q, err_d;

    logic [NR-1:0]            rr_grant;
    logic [PW-1:0]            win;
    logic                     pl_found;
    logic                     viol;

    lag_rr_arbiter #(.NR(NR), .PW(PW)) u_rr (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant)
    );

    always_comb begin
        for (int unsigned j = 0; j < NPL; j++) begin
            pl_free[j]   = (state_q[j] == FREE);
            pl_status[j] = (cnt_q[j] != '0);
            pl_empty[j]  = (cnt_q[j] == FULL);
        end
    end

    assign err = err_q;

    // Grant is gated by rst so it reads zero during reset even though the
    // pointer and PL states already show an idle, fully free trunk.
    always_comb begin
        grant    = (!rst && (|pl_free)) ? rr_grant : '0;
        grant_pl = '0;
        pl_found = 1'b0;
        for (int unsigned j = 0; j < NPL; j++) begin
            if ((|grant) && !pl_found && pl_free[j]) begin
                grant_pl[j] = 1'b1;
                pl_found    = 1'b1;
            end
        end
    end

    always_comb begin
        win = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (grant[i]) win = PW'(i);
        end
        ptr_d = ptr_q;
        if (|grant) ptr_d = (win == PW'(NR - 1)) ? '0 : win + 1'b1;
    end

    // A violating PL keeps its counter and state; only a fresh allocation
    // can still move it (allocation only ever targets a FREE PL).
    always_comb begin
        err_d = err_q;
        viol  = 1'b0;
        for (int unsigned j = 0; j < NPL; j++) begin
            cnt_d[j]   = cnt_q[j];
            state_d[j] = state_q[j];
            viol = (flit_valid[j] && !credit_in[j] && cnt_q[j] == '0)   ||
                   (credit_in[j] && !flit_valid[j] && cnt_q[j] == FULL) ||
                   (flit_valid[j] && state_q[j] == FREE);
            if (viol) begin
                err_d = 1'b1;
            end else begin
                if (flit_valid[j] && !credit_in[j])      cnt_d[j] = cnt_q[j] - 1'b1;
                else if (credit_in[j] && !flit_valid[j]) cnt_d[j] = cnt_q[j] + 1'b1;
                case (state_q[j])
                    BUSY:    if (flit_valid[j] && flit_tail[j])
                                 state_d[j] = (cnt_d[j] == FULL) ? FREE : DRAIN;
                    DRAIN:   if (cnt_d[j] == FULL) state_d[j] = FREE;
                    default: ;
                endcase
            end
            if (grant_pl[j]) state_d[j] = BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 0; j < NPL; j++) begin
                state_q[j] <= FREE;
                cnt_q[j]   <= FULL;
            end
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < NPL; j++) begin
                state_q[j] <= state_d[j];
                cnt_q[j]   <= cnt_d[j];
            end
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

endmodule
